// File: rtl/debounce_multi.sv
// debounce_multi: NUM_CH independent push-button debouncers.
//
// Each channel synchronises its raw key through two flops, normalises the
// polarity so 1 always means "pressed", and accepts a new level only after
// it has been stable for STABLE_CYC cycles. Accepted edges produce one-cycle
// press/release pulses and flip a per-channel toggle level.
//
// Optional feature (macro DEBOUNCE_MULTI_LONGPRESS_EN): a per-channel hold
// counter produces a single olong pulse LONG_CYC cycles after opress. When
// the macro is undefined the hold counters are absent and olong is tied 0.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   ikey     [NUM_CH] raw asynchronous button inputs
//   ostate   [NUM_CH] debounced pressed level (1 = pressed)
//   opress   [NUM_CH] one-cycle pulse on accepted press
//   orelease [NUM_CH] one-cycle pulse on accepted release
//   otoggle  [NUM_CH] level inverting on every press
//   olong    [NUM_CH] one-cycle long-press pulse

module debounce_lane #(
  parameter int STABLE_CYC = 1_300_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic state,
  output logic press,
  output logic rel,
  output logic toggle
);
  localparam int            CW   = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);
  // Raw level of a released key; the synchroniser resets to it so that a
  // key held through reset is seen as a fresh press afterwards.
  localparam logic          IDLE = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          lvl;
  logic          flip;
  logic [CW-1:0] cnt;

  assign lvl  = sync[1] ^ IDLE;
  assign flip = (lvl != state) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= {2{IDLE}};
      cnt    <= '0;
      state  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      toggle <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= flip & ~state;
      rel   <= flip & state;
      if (flip) begin
        state <= ~state;
        if (!state) toggle <= ~toggle;
      end
      // Any return to the accepted level restarts the stability window.
      if (lvl == state || flip) cnt <= '0;
      else if (cnt != LAST)     cnt <= cnt + 1'b1;
    end
  end
endmodule

module debounce_multi #(
  parameter int NUM_CH     = 4,
  parameter int STABLE_CYC = 1_300_000,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_CYC   = 65_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ikey,
  output logic [NUM_CH-1:0] ostate,
  output logic [NUM_CH-1:0] opress,
  output logic [NUM_CH-1:0] orelease,
  output logic [NUM_CH-1:0] otoggle,
  output logic [NUM_CH-1:0] olong
);
  if (NUM_CH < 1 || STABLE_CYC < 2 || LONG_CYC < 1) begin : g_bad_param
    $error("debounce_multi: parameter out of range");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_lane #(
      .STABLE_CYC (STABLE_CYC),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .key    (ikey[i]),
      .state  (ostate[i]),
      .press  (opress[i]),
      .rel    (orelease[i]),
      .toggle (otoggle[i])
    );

`ifdef DEBOUNCE_MULTI_LONGPRESS_EN
    localparam int            HW    = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HLAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HMAX  = HW'(LONG_CYC);

    // hcnt is 0 while released, so it starts from 0 at each press and
    // equals k k cycles later; saturating at LONG_CYC gives one pulse.
    logic [HW-1:0] hcnt;
    logic          lng;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hcnt <= '0;
        lng  <= 1'b0;
      end else begin
        lng <= ostate[i] && (hcnt == HLAST);
        if (!ostate[i])        hcnt <= '0;
        else if (hcnt != HMAX) hcnt <= hcnt + 1'b1;
      end
    end
    assign olong[i] = lng;
`else
    assign olong[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;
  localparam int NC = 4;
`ifdef DEBOUNCE_MULTI_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] ikey;
  logic [NC-1:0] ostate, opress, orelease, otoggle, olong;
  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .NUM_CH(NC), .STABLE_CYC(8), .ACTIVE_LOW(1), .LONG_CYC(32)
  ) dut (
    .clk(clk), .rst(rst), .ikey(ikey), .ostate(ostate), .opress(opress),
    .orelease(orelease), .otoggle(otoggle), .olong(olong)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    ikey = 4'hF;
    step(); step();
    chk("rst_state",   ostate,   0);
    chk("rst_press",   opress,   0);
    chk("rst_release", orelease, 0);
    chk("rst_toggle",  otoggle,  0);
    chk("rst_long",    olong,    0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("idle_state", ostate, 0);

    // Clean press on channel 0: opress in cycle 10
    ikey = 4'b1110;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("p0_wait_press", opress, 0);
    end
    step();
    chk("p0_press",  opress,  4'h1);
    chk("p0_state",  ostate,  4'h1);
    chk("p0_toggle", otoggle, 4'h1);
    step();
    chk("p0_press_1cyc", opress, 0);
    ikey = 4'hF;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("r0_wait_rel", orelease, 0);
    end
    step();
    chk("r0_release", orelease, 4'h1);
    chk("r0_state",   ostate,   0);
    chk("r0_toggle",  otoggle,  4'h1);
    step();
    chk("r0_rel_1cyc", orelease, 0);

    // Bounce on channel 1: 5 low / 2 high, four times
    for (int r = 0; r < 4; r++) begin
      ikey = 4'b1101;
      for (int k = 0; k < 5; k++) begin step(); chk("b1_press", opress, 0); end
      ikey = 4'hF;
      for (int k = 0; k < 2; k++) begin step(); chk("b1_press", opress, 0); end
    end
    for (int k = 0; k < 12; k++) begin step(); chk("b1_press_tail", opress, 0); end
    chk("b1_state", ostate, 0);

    // All four together, released 20 cycles later
    ikey = 4'h0;
    for (int k = 1; k < 10; k++) begin step(); chk("all_wait", opress, 0); end
    step();
    chk("all_press",  opress,  4'hF);
    chk("all_state",  ostate,  4'hF);
    chk("all_toggle", otoggle, 4'hE);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("all_no_press", opress, 0);
      chk("all_no_long",  olong,  0);
    end
    ikey = 4'hF;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("all_wait_rel", orelease, 0);
      chk("all_no_long",  olong,    0);
    end
    step();
    chk("all_release", orelease, 4'hF);
    chk("all_state0",  ostate,   0);
    step();
    chk("all_rel_1cyc", orelease, 0);

    // Reset at count 5 of a pending press on channel 2, key held low
    ikey = 4'b1011;
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1;
    #1;
    chk("mr_state",  ostate,   0);
    chk("mr_press",  opress,   0);
    chk("mr_rel",    orelease, 0);
    chk("mr_toggle", otoggle,  0);
    chk("mr_long",   olong,    0);
    step(); step();
    rst = 1'b0;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("mr_wait", opress, 0);
      chk("mr_wait_rel", orelease, 0);
    end
    step();
    chk("mr_press_after", opress,  4'h4);
    chk("mr_state_after", ostate,  4'h4);
    chk("mr_toggle_after", otoggle, 4'h4);
    ikey = 4'hF;
    for (int k = 0; k < 10; k++) step();
    chk("mr_release", orelease, 4'h4);

    // 100-cycle hold on channel 3 for long press
    ikey = 4'b0111;
    for (int k = 1; k < 10; k++) step();
    step();
    chk("lp_press", opress, 4'h8);
    for (int k = 1; k <= 90; k++) begin
      step();
      chk("lp_long", olong, (LP && k == 32) ? 4'h8 : 4'h0);
    end
    ikey = 4'hF;
    for (int k = 1; k < 10; k++) begin
      step();
      chk("lp_long_rel", olong, 0);
    end
    step();
    chk("lp_release", orelease, 4'h8);
    chk("lp_long_end", olong, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent button channels (>=1).
REQ-002 The block SHALL have parameter STABLE_CYC, default 1_300_000, clock cycles an input must stay stable before acceptance (>=2; 20 ms at 65 MHz).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means pressed = logic 0 on ikey.
REQ-004 The block SHALL have parameter LONG_CYC, default 65_000_000, clock cycles of continuous debounced press that form a long press (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit, sole system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port ikey, input, NUM_CH bits, raw asynchronous button inputs.
REQ-008 The block SHALL have port ostate, output, NUM_CH bits, debounced pressed level (1 = pressed, regardless of ACTIVE_LOW).
REQ-009 The block SHALL have port opress, output, NUM_CH bits, one-cycle pulse on the accepted press edge.
REQ-010 The block SHALL have port orelease, output, NUM_CH bits, one-cycle pulse on the accepted release edge.
REQ-011 The block SHALL have port otoggle, output, NUM_CH bits, level that inverts on each opress.
REQ-012 The block SHALL have port olong, output, NUM_CH bits, one-cycle long-press pulse (see Configuration).

Function
REQ-013 Each channel SHALL pass ikey through a two-flop synchronizer and normalise polarity (invert when ACTIVE_LOW=1); no logic SHALL use raw ikey.
REQ-014 Each channel SHALL keep a counter of width clog2(STABLE_CYC+1), cleared on every cycle where the synchronized level equals ostate.
REQ-015 The counter SHALL increment on every cycle where the synchronized level differs from ostate; any return to equality (glitch) SHALL clear it.
REQ-016 On the edge where the counter equals STABLE_CYC-1 and the mismatch persists, ostate SHALL flip and the counter SHALL clear.
REQ-017 Latency SHALL be exactly 2+STABLE_CYC clk cycles from a clean ikey edge to the ostate change; pulses narrower than STABLE_CYC cycles SHALL never change ostate.
REQ-018 opress/orelease SHALL be registered and asserted for exactly one cycle, in the cycle ostate first shows the new value.
REQ-019 otoggle SHALL invert in the same cycle opress asserts; release SHALL not affect it.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 The counter SHALL saturate and never wrap.

Reset
REQ-022 While rst=1, synchronizer flops SHALL hold the inactive level, and counters SHALL be 0.
REQ-023 While rst=1, ostate, opress, orelease, otoggle, and olong SHALL all be 0.
REQ-024 Reset asserted mid-count or mid-press SHALL abort immediately, with no pulse emitted on reset release.
REQ-025 A button held through reset release SHALL be accepted as a new press after 2+STABLE_CYC cycles.

Configuration
REQ-026 The long-press feature SHALL be controlled by the macro DEBOUNCE_MULTI_LONGPRESS_EN.
REQ-027 With DEBOUNCE_MULTI_LONGPRESS_EN defined, each channel SHALL have a hold counter of width clog2(LONG_CYC+1), cleared on opress and counting while ostate=1.
REQ-028 With DEBOUNCE_MULTI_LONGPRESS_EN defined, olong SHALL pulse once when the hold counter reaches LONG_CYC; the counter then saturates, giving exactly one olong per press, and a release before LONG_CYC gives none.
REQ-029 Without DEBOUNCE_MULTI_LONGPRESS_EN, the hold counters SHALL not be synthesised, olong SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-030 With NUM_CH=4, STABLE_CYC=8, ACTIVE_LOW=1, driving ikey[0] 1->0 clean SHALL produce opress[0] in cycle 10, set ostate[0]=1, and toggle otoggle[0] 0->1.
REQ-031 Bouncing ikey[1] low for 5 cycles, then high for 2 cycles, repeated 4 times, SHALL produce no opress[1] and keep ostate[1]=0.
REQ-032 Pressing all four channels in the same cycle, then releasing after 20 cycles, SHALL give opress=4'hF in one cycle and orelease=4'hF in one cycle, 20 cycles later.
REQ-033 Asserting rst at count 5 of a pending press SHALL zero all outputs; after release with ikey still low, opress SHALL assert 10 cycles later.
REQ-034 With the macro defined and LONG_CYC=32, a 100-cycle hold SHALL give exactly one olong, 32 cycles after opress; a 20-cycle hold SHALL give none.
REQ-035 With the macro undefined, the same 100-cycle hold SHALL keep olong=0 throughout.
